// File: rtl/ram8_clr.sv
// ram8_clr: 8 x 16-bit Hack register bank with a sequential bulk-clear engine.
// Leaf bank beneath RAM64/RAM512; reads are combinational, writes and clears are clocked.

module dmux8way (
    input  logic       in,
    input  logic [2:0] sel,
    output logic [7:0] out
);
    always_comb begin
        out      = '0;
        out[sel] = in;
    end
endmodule

module mux8way16 #(
    parameter int W = 16
) (
    input  logic [7:0][W-1:0] d,
    input  logic [2:0]        sel,
    output logic [W-1:0]      out
);
    assign out = d[sel];
endmodule

module ram8_clr #(
    parameter int               WIDTH     = 16,
    parameter logic [WIDTH-1:0] CLEAR_VAL = '0
) (
    input  logic             clock,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in,
    input  logic             load,
    input  logic [2:0]       address,
    input  logic             clear,
    output logic [WIDTH-1:0] out,
    output logic             busy
);
    typedef enum logic {IDLE, CLEAR} state_t;

    state_t                  state, state_nx;
    logic [2:0]              cnt, cnt_nx;
    logic                    busy_nx;
    logic                    wr_load;
    logic [7:0]              we;
    logic [7:0][WIDTH-1:0]   mem;

    // A clear request in IDLE takes priority and drops any coincident load.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        busy_nx  = busy;
        wr_load  = 1'b0;
        unique case (state)
            IDLE: begin
                if (clear) begin
                    state_nx = CLEAR;
                    cnt_nx   = 3'd0;
                    busy_nx  = 1'b1;
                end else begin
                    wr_load = load;
                end
            end
            CLEAR: begin
                cnt_nx = cnt + 3'd1;
                if (cnt == 3'd7) begin
                    state_nx = IDLE;
                    busy_nx  = 1'b0;
                end
            end
        endcase
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= 3'd0;
            busy  <= 1'b0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            busy  <= busy_nx;
        end
    end

    dmux8way u_dmux (
        .in  (wr_load),
        .sel (address),
        .out (we)
    );

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            mem <= '0;
        end else if (state == CLEAR) begin
            mem[cnt] <= CLEAR_VAL;
        end else begin
            for (int i = 0; i < 8; i++) begin
                if (we[i]) mem[i] <= in;
            end
        end
    end

    mux8way16 #(.W(WIDTH)) u_mux (
        .d   (mem),
        .sel (address),
        .out (out)
    );
endmodule
